// File: rtl/muller_c_sync_array.sv
// muller_c_sync_array: clocked array of N-input Muller C-elements.
// Each channel has optional input synchronisers and per-input bubbles.
// It also provides edge pulses, saturating transition counters and
// array-wide all-high/all-low flags.
// Optional feature macro: MULLER_C_ASYM_EN adds PLUS_MASK (plus-only inputs).
module muller_c_sync_array #(
    parameter int CHANNELS    = 2,
    parameter int INPUTS      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int RESET_VAL   = 0,
    parameter logic [CHANNELS*INPUTS-1:0] INV_MASK = '0
`ifdef MULLER_C_ASYM_EN
    ,
    parameter logic [CHANNELS*INPUTS-1:0] PLUS_MASK = '0
`endif
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [CHANNELS*INPUTS-1:0] c_in,
    input  logic [CHANNELS-1:0]       hold,
    input  logic                      cnt_clr,
    output logic [CHANNELS-1:0]       c_out,
    output logic [CHANNELS-1:0]       c_rise,
    output logic [CHANNELS-1:0]       c_fall,
    output logic                      all_high,
    output logic                      all_low,
    output logic [CHANNELS*CNT_W-1:0] trans_cnt
);

    localparam int VEC_W = CHANNELS * INPUTS;
    localparam logic RST_BIT = (RESET_VAL == 1);

    generate
        if (INPUTS < 2) begin : g_err_inputs
            $error("muller_c_sync_array: INPUTS must be >= 2");
        end
        if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_err_sync
            $error("muller_c_sync_array: SYNC_STAGES must be 0..3");
        end
        if (CNT_W < 1) begin : g_err_cnt
            $error("muller_c_sync_array: CNT_W must be >= 1");
        end
        if (RESET_VAL != 0 && RESET_VAL != 1) begin : g_err_rst
            $error("muller_c_sync_array: RESET_VAL must be 0 or 1");
        end
    endgenerate

    // Saturating increment: a counter stuck at all-ones stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    logic [VEC_W-1:0] sync_out;
    logic [VEC_W-1:0] eff;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_out = c_in;
        end else begin : g_sync
            logic [VEC_W-1:0] sync_q [SYNC_STAGES];

            // Pad synchroniser chain; cleared by reset so in-flight samples are dropped.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q[0] <= c_in;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= sync_q[s-1];
                    end
                end
            end

            assign sync_out = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign eff = sync_out ^ INV_MASK;

    logic [CHANNELS-1:0] c_next;
    logic [INPUTS-1:0]   ch_bits;
`ifdef MULLER_C_ASYM_EN
    logic [INPUTS-1:0]   ch_plus;
`endif

    // C-element next-state: unanimous 1 sets, fall condition clears, otherwise hold.
    always_comb begin
        c_next  = c_out;
        ch_bits = '0;
`ifdef MULLER_C_ASYM_EN
        ch_plus = '0;
`endif
        for (int k = 0; k < CHANNELS; k++) begin
            ch_bits = eff[k*INPUTS +: INPUTS];
`ifdef MULLER_C_ASYM_EN
            ch_plus = PLUS_MASK[k*INPUTS +: INPUTS];
`endif
            if (!hold[k]) begin
                if (&ch_bits) begin
                    c_next[k] = 1'b1;
`ifdef MULLER_C_ASYM_EN
                end else if (((ch_bits & ~ch_plus) == '0) && !(&ch_plus)) begin
`else
                end else if (ch_bits == '0) begin
`endif
                    c_next[k] = 1'b0;
                end
            end
        end
    end

    // Output state, edge pulses, array flags and transition counters.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            c_out     <= {CHANNELS{RST_BIT}};
            c_rise    <= '0;
            c_fall    <= '0;
            all_high  <= RST_BIT;
            all_low   <= !RST_BIT;
            trans_cnt <= '0;
        end else begin
            c_out    <= c_next;
            c_rise   <= c_next & ~c_out;
            c_fall   <= ~c_next & c_out;
            all_high <= &c_out;
            all_low  <= ~|c_out;
            for (int k = 0; k < CHANNELS; k++) begin
                if (cnt_clr) begin
                    trans_cnt[k*CNT_W +: CNT_W] <= '0;
                end else if (c_next[k] != c_out[k]) begin
                    trans_cnt[k*CNT_W +: CNT_W] <= sat_inc(trans_cnt[k*CNT_W +: CNT_W]);
                end
            end
        end
    end

endmodule

// File: tb/tb_muller_c_sync_array.sv
// Directed self-checking bench for muller_c_sync_array (default parameters).
// The asymmetric scenario is compiled only when MULLER_C_ASYM_EN is defined.
module tb_muller_c_sync_array;

    logic        clk;
    logic        rst;
    logic [5:0]  c_in;
    logic [1:0]  hold;
    logic        cnt_clr;
    logic [1:0]  c_out;
    logic [1:0]  c_rise;
    logic [1:0]  c_fall;
    logic        all_high;
    logic        all_low;
    logic [15:0] trans_cnt;

    int checks   = 0;
    int failures = 0;

    muller_c_sync_array #(
        .CHANNELS(2), .INPUTS(3), .SYNC_STAGES(2), .CNT_W(8), .RESET_VAL(0),
        .INV_MASK(6'b000_000)
`ifdef MULLER_C_ASYM_EN
        , .PLUS_MASK(6'b000_100)
`endif
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .c_in(c_in), .hold(hold), .cnt_clr(cnt_clr),
        .c_out(c_out), .c_rise(c_rise), .c_fall(c_fall), .all_high(all_high),
        .all_low(all_low), .trans_cnt(trans_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; c_in = '0; hold = '0; cnt_clr = 1'b0;
        tick(2);
        rst = 1'b0;
        checks++; if (c_out !== 2'b00) begin failures++; $display("FAIL reset_c_out got=%b exp=00", c_out); end
        checks++; if (all_low !== 1'b1) begin failures++; $display("FAIL reset_all_low got=%b exp=1", all_low); end
        checks++; if (all_high !== 1'b0) begin failures++; $display("FAIL reset_all_high got=%b exp=0", all_high); end
        checks++; if (trans_cnt !== 16'h0000) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", trans_cnt); end
        checks++; if ((c_rise | c_fall) !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b/%b exp=00/00", c_rise, c_fall); end
    endtask

    task automatic test_rise_hold();
        c_in = 6'b000_111;
        tick(2);
        checks++; if (c_out !== 2'b00) begin failures++; $display("FAIL rise_early got=%b exp=00", c_out); end
        tick(1);
        checks++; if (c_out !== 2'b01) begin failures++; $display("FAIL rise_c_out got=%b exp=01", c_out); end
        checks++; if (c_rise !== 2'b01) begin failures++; $display("FAIL rise_pulse got=%b exp=01", c_rise); end
        checks++; if (trans_cnt !== 16'h0001) begin failures++; $display("FAIL rise_cnt got=%h exp=0001", trans_cnt); end
        tick(1);
        checks++; if (c_rise !== 2'b00) begin failures++; $display("FAIL rise_pulse_end got=%b exp=00", c_rise); end
        checks++; if (all_low !== 1'b0) begin failures++; $display("FAIL rise_all_low got=%b exp=0", all_low); end
        c_in = 6'b000_101;
        tick(4);
        checks++; if (c_out !== 2'b01) begin failures++; $display("FAIL mixed_keep got=%b exp=01", c_out); end
        checks++; if (trans_cnt !== 16'h0001) begin failures++; $display("FAIL mixed_cnt got=%h exp=0001", trans_cnt); end
    endtask

    task automatic test_fall();
        c_in = 6'b000_000;
        tick(2);
        checks++; if (c_out !== 2'b01) begin failures++; $display("FAIL fall_early got=%b exp=01", c_out); end
        tick(1);
        checks++; if (c_out !== 2'b00) begin failures++; $display("FAIL fall_c_out got=%b exp=00", c_out); end
        checks++; if (c_fall !== 2'b01) begin failures++; $display("FAIL fall_pulse got=%b exp=01", c_fall); end
        checks++; if (trans_cnt !== 16'h0002) begin failures++; $display("FAIL fall_cnt got=%h exp=0002", trans_cnt); end
        checks++; if (all_low !== 1'b0) begin failures++; $display("FAIL fall_all_low_lag got=%b exp=0", all_low); end
        tick(1);
        checks++; if (all_low !== 1'b1) begin failures++; $display("FAIL fall_all_low got=%b exp=1", all_low); end
        checks++; if (c_fall !== 2'b00) begin failures++; $display("FAIL fall_pulse_end got=%b exp=00", c_fall); end
    endtask

    task automatic test_hold_release();
        hold = 2'b10; c_in = 6'b111_111;
        tick(4);
        checks++; if (c_out !== 2'b01) begin failures++; $display("FAIL hold_c_out got=%b exp=01", c_out); end
        checks++; if (trans_cnt !== 16'h0003) begin failures++; $display("FAIL hold_cnt got=%h exp=0003", trans_cnt); end
        hold = 2'b00;
        tick(1);
        checks++; if (c_out !== 2'b11) begin failures++; $display("FAIL release_c_out got=%b exp=11", c_out); end
        checks++; if (c_rise !== 2'b10) begin failures++; $display("FAIL release_pulse got=%b exp=10", c_rise); end
        checks++; if (trans_cnt !== 16'h0103) begin failures++; $display("FAIL release_cnt got=%h exp=0103", trans_cnt); end
        checks++; if (all_high !== 1'b0) begin failures++; $display("FAIL release_all_high_lag got=%b exp=0", all_high); end
        tick(1);
        checks++; if (all_high !== 1'b1) begin failures++; $display("FAIL release_all_high got=%b exp=1", all_high); end
    endtask

    task automatic test_saturation_clear();
        for (int i = 0; i < 300; i++) begin
            c_in = (i % 2 == 0) ? 6'b111_000 : 6'b111_111;
            tick(1);
        end
        tick(4);
        checks++; if (trans_cnt[7:0] !== 8'd255) begin failures++; $display("FAIL sat_cnt0 got=%0d exp=255", trans_cnt[7:0]); end
        checks++; if (trans_cnt[15:8] !== 8'd1) begin failures++; $display("FAIL sat_cnt1 got=%0d exp=1", trans_cnt[15:8]); end
        checks++; if (c_out !== 2'b11) begin failures++; $display("FAIL sat_c_out got=%b exp=11", c_out); end
        c_in = 6'b111_000;
        tick(2);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        checks++; if (c_fall !== 2'b01) begin failures++; $display("FAIL clr_fall got=%b exp=01", c_fall); end
        checks++; if (trans_cnt !== 16'h0000) begin failures++; $display("FAIL clr_cnt got=%h exp=0000", trans_cnt); end
        c_in = 6'b111_111;
        tick(3);
        checks++; if (trans_cnt !== 16'h0001) begin failures++; $display("FAIL clr_resume got=%h exp=0001", trans_cnt); end
    endtask

    task automatic test_reset_mid();
        tick(1);
        checks++; if (c_out !== 2'b11) begin failures++; $display("FAIL mid_pre got=%b exp=11", c_out); end
        rst = 1'b1; c_in = 6'b000_000;
        tick(1);
        rst = 1'b0;
        checks++; if (c_out !== 2'b00) begin failures++; $display("FAIL mid_c_out got=%b exp=00", c_out); end
        tick(3);
        checks++; if (c_out !== 2'b00) begin failures++; $display("FAIL mid_lost got=%b exp=00", c_out); end
        checks++; if (trans_cnt !== 16'h0000) begin failures++; $display("FAIL mid_cnt got=%h exp=0000", trans_cnt); end
        checks++; if (all_low !== 1'b1) begin failures++; $display("FAIL mid_all_low got=%b exp=1", all_low); end
    endtask

`ifdef MULLER_C_ASYM_EN
    task automatic test_asym();
        c_in = 6'b000_111;
        tick(3);
        checks++; if (c_out[0] !== 1'b1) begin failures++; $display("FAIL asym_rise got=%b exp=1", c_out[0]); end
        c_in = 6'b000_100;
        tick(3);
        checks++; if (c_out[0] !== 1'b0) begin failures++; $display("FAIL asym_fall got=%b exp=0", c_out[0]); end
    endtask
`endif

    initial begin
        rst = 1'b1; c_in = '0; hold = '0; cnt_clr = 1'b0;
        tick(1);
        test_reset();
        test_rise_hold();
        test_fall();
        test_hold_release();
        test_saturation_clear();
        test_reset_mid();
`ifdef MULLER_C_ASYM_EN
        test_asym();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
